imm_decode_pipe: RTL and testbench

Pipelined, parametrised immediate decoder for the decode stage. It classifies each instruction word from its own opcode, so no one-hot type inputs are needed, and assembles the sign-extended immediate at XLEN width. Results come out through a two-stage valid/ready pipeline with flush and a saturating illegal-opcode counter. It sits between fetch and the register-read/ALU operand mux.

---
 rtl/imm_pkg.sv | 30 +++
 rtl/imm_assemble.sv | 30 +++
 rtl/imm_decode_pipe.sv | 127 ++++++++++++
 tb/tb_imm_decode_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - format codes, opcodes and sign-extend helper for imm_decode_pipe
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Widest datapath is 64; callers truncate to their XLEN.
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_assemble.sv
// rtl/imm_assemble.sv - combinational format-to-immediate mux, sign-extended to XLEN
module imm_assemble
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      // uimm has a zero top bit, so the shared sign extension leaves it zero-extended
      FMT_Z:   imm32 = {27'b0, instr[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(sext32(imm32));

endmodule

// File: rtl/imm_decode_pipe.sv
// rtl/imm_decode_pipe.sv - two-stage immediate decoder with flush and illegal counter
// Optional IMM_CSR_EN: SYSTEM words with funct3[2]=1 decode as fmt Z (uimm).
module imm_decode_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  fmt_e            dec_fmt;
  logic            s1_valid_q, s1_valid_d;
  logic [31:7]     s1_instr_q, s1_instr_d;
  fmt_e            s1_fmt_q, s1_fmt_d;
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s2_imm_q, s2_imm_d;
  fmt_e            s2_fmt_q, s2_fmt_d;
  logic            s2_ill_q, s2_ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] asm_imm;
  logic            s1_advance;
  logic            accept;

  always_comb begin
    dec_fmt = FMT_NONE;
    case (in_instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: dec_fmt = FMT_I;
      OP_IMM32:                 dec_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
      OP_STORE:                 dec_fmt = FMT_S;
      OP_BRANCH:                dec_fmt = FMT_B;
      OP_LUI, OP_AUIPC:         dec_fmt = FMT_U;
      OP_JAL:                   dec_fmt = FMT_J;
`ifdef IMM_CSR_EN
      OP_SYSTEM:                dec_fmt = in_instr[14] ? FMT_Z : FMT_I;
`else
      OP_SYSTEM:                dec_fmt = FMT_I;
`endif
      default:                  dec_fmt = FMT_NONE;
    endcase
  end

  imm_assemble #(.XLEN(XLEN)) u_assemble (
    .instr (s1_instr_q),
    .fmt   (s1_fmt_q),
    .imm   (asm_imm)
  );

  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = !flush && (!s1_valid_q || s1_advance);
  assign accept     = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s1_fmt_d   = s1_fmt_q;
    s2_valid_d = s2_valid_q;
    s2_imm_d   = s2_imm_q;
    s2_fmt_d   = s2_fmt_q;
    s2_ill_d   = s2_ill_q;
    cnt_d      = cnt_q;

    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_imm_d = asm_imm;
        s2_fmt_d = s1_fmt_q;
        s2_ill_d = (s1_fmt_q == FMT_NONE);
      end
      s1_valid_d = 1'b0;
    end
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_instr_d = in_instr[31:7];
      s1_fmt_d   = dec_fmt;
    end

    // A flushed entry is never counted, even if the consumer happens to accept it
    if (s2_valid_q && out_ready && s2_ill_q && !flush && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_fmt_q   <= FMT_NONE;
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_fmt_q   <= FMT_NONE;
      s2_ill_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s1_fmt_q   <= s1_fmt_d;
      s2_valid_q <= s2_valid_d;
      s2_imm_q   <= s2_imm_d;
      s2_fmt_q   <= s2_fmt_d;
      s2_ill_q   <= s2_ill_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_imm     = s2_imm_q;
  assign out_fmt     = s2_fmt_q;
  assign out_illegal = s2_ill_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// tb/tb_imm_decode_pipe.sv - scoreboard bench for imm_decode_pipe at XLEN 32 and 64
module tb_imm_decode_pipe;

  localparam int CNT_W = 4;
  localparam logic [3:0] CNT_MAX = 4'hF;

  logic clk, rst;
  logic in_valid, flush, out_ready;
  logic [31:0] in_instr;

  logic in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32;
  logic [2:0] out_fmt32;
  logic [CNT_W-1:0] cnt32;

  logic in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64;
  logic [2:0] out_fmt64;
  logic [CNT_W-1:0] cnt64;

  imm_decode_pipe #(.XLEN(32), .CNT_W(CNT_W)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_ill32), .illegal_cnt(cnt32)
  );

  imm_decode_pipe #(.XLEN(64), .CNT_W(CNT_W)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_ill64), .illegal_cnt(cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } res_t;

  typedef struct {
    res_t r32;
    res_t r64;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic [3:0] mcnt32 = '0;
  logic [3:0] mcnt64 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [31:0] w, input int xlen);
    res_t r;
    logic signed [63:0] s;
    logic [63:0] sx, t;
    s  = $signed(w);
    sx = s >>> 31;
    r.imm = '0;
    r.fmt = 3'd0;
    r.ill = 1'b0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: begin r.fmt = 3'd1; r.imm = s >>> 20; end
      7'h1B: if (xlen == 64) begin r.fmt = 3'd1; r.imm = s >>> 20; end else r.ill = 1'b1;
      7'h73: begin
`ifdef IMM_CSR_EN
        if (w[14]) begin r.fmt = 3'd6; r.imm = 64'(w[19:15]); end
        else begin r.fmt = 3'd1; r.imm = s >>> 20; end
`else
        r.fmt = 3'd1; r.imm = s >>> 20;
`endif
      end
      7'h23: begin r.fmt = 3'd2; t = s >>> 25; r.imm = (t << 5) | 64'(w[11:7]); end
      7'h63: begin
        r.fmt = 3'd3;
        r.imm = (sx << 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1);
      end
      7'h37, 7'h17: begin r.fmt = 3'd4; t = s >>> 12; r.imm = t << 12; end
      7'h6F: begin
        r.fmt = 3'd5;
        r.imm = (sx << 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11) | (64'(w[30:21]) << 1);
      end
      default: r.ill = 1'b1;
    endcase
    if (xlen == 32) r.imm[63:32] = '0;
    return r;
  endfunction

  // Inputs change 1 time unit after the rising edge; in_ready is judged from occupancy.
  task automatic drive(input logic v, input logic [31:0] w, input logic r, input logic f);
    logic er;
    exp_t e;
    in_valid = v; in_instr = w; out_ready = r; flush = f;
    #1;
    er = !f && (q.size() < 2 || r);
    check("in_ready32", 64'(in_ready32), 64'(er));
    check("in_ready64", 64'(in_ready64), 64'(er));
    if (f) q.delete();
    else if (v && er) begin
      e.r32 = model(w, 32);
      e.r64 = model(w, 64);
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] imm, input logic [2:0] fmt);
    check({name, "_valid"}, 64'(out_valid32), 64'd1);
    check({name, "_imm"}, 64'(out_imm32), 64'(imm));
    check({name, "_fmt"}, 64'(out_fmt32), 64'(fmt));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("cnt32", 64'(cnt32), 64'(mcnt32));
      check("cnt64", 64'(cnt64), 64'(mcnt64));
      if (out_valid32 && !flush) begin
        if (q.size() == 0) check("spurious_out", 64'(out_valid32), 64'd0);
        else begin
          e = q[0];
          check("imm32", 64'(out_imm32), e.r32.imm);
          check("fmt32", 64'(out_fmt32), 64'(e.r32.fmt));
          check("ill32", 64'(out_ill32), 64'(e.r32.ill));
          check("valid64", 64'(out_valid64), 64'd1);
          check("imm64", out_imm64, e.r64.imm);
          check("fmt64", 64'(out_fmt64), 64'(e.r64.fmt));
          check("ill64", 64'(out_ill64), 64'(e.r64.ill));
          if (out_ready) begin
            void'(q.pop_front());
            if (e.r32.ill && mcnt32 != CNT_MAX) mcnt32 = mcnt32 + 4'd1;
            if (e.r64.ill && mcnt64 != CNT_MAX) mcnt64 = mcnt64 + 4'd1;
          end
        end
      end
    end
  end

  function automatic logic [31:0] rand_word();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F, 7'h00};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_valid", 64'(out_valid32), 64'd0);
    check("rst_imm", 64'(out_imm32), 64'd0);
    check("rst_fmt", 64'(out_fmt32), 64'd0);
    check("rst_ill", 64'(out_ill32), 64'd0);
    check("rst_cnt", 64'(cnt32), 64'd0);
    check("rst_valid64", 64'(out_valid64), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 64'(in_ready32), 64'd1);

    // ADDI latency and sign extension at both widths
    drive(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    check("addi_lat1", 64'(out_valid32), 64'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("addi", 32'hFFFFFFFF, 3'd1);
    check("addi_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Back-to-back stream, no bubbles
    drive(1'b1, 32'hFE112E23, 1'b1, 1'b0);
    drive(1'b1, 32'h123450B7, 1'b1, 1'b0);
    expect_out("sw", 32'hFFFFFFFC, 3'd2);
    drive(1'b1, 32'hFF9FF06F, 1'b1, 1'b0);
    expect_out("lui", 32'h12345000, 3'd4);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("jal", 32'hFFFFFFF8, 3'd5);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("stream_drained", 64'(q.size()), 64'd0);

    // Backpressure hold on BEQ
    drive(1'b1, 32'hFE0008E3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h00F00013 + (i << 20), 1'b0, 1'b0);
      expect_out("beq_hold", 32'hFFFFFFF0, 3'd3);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("beq_drained", 64'(q.size()), 64'd0);

    // CSRRWI
    drive(1'b1, 32'h3002D073, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef IMM_CSR_EN
    expect_out("csrrwi", 32'h00000005, 3'd6);
`else
    expect_out("csrrwi", 32'h00000300, 3'd1);
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with both stages full and a word offered
    drive(1'b1, 32'h0000007F, 1'b0, 1'b0);
    drive(1'b1, 32'h0000007F, 1'b0, 1'b0);
    check("pre_flush_valid", 64'(out_valid32), 64'd1);
    drive(1'b1, 32'hFFF00093, 1'b0, 1'b1);
    check("flush_valid", 64'(out_valid32), 64'd0);
    check("flush_cnt", 64'(cnt32), 64'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush_not_taken", 64'(out_valid32), 64'd0);

    // Illegal stream saturates the counter
    for (int i = 0; i < 20; i++) drive(1'b1, 32'h0000007F, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("sat_cnt32", 64'(cnt32), 64'(CNT_MAX));
    check("sat_cnt64", 64'(cnt64), 64'(CNT_MAX));

    // Asynchronous reset mid-stream
    drive(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    drive(1'b1, 32'h123450B7, 1'b0, 1'b0);
    check("pre_rst_valid", 64'(out_valid32), 64'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_valid32", 64'(out_valid32), 64'd0);
    check("async_rst_valid64", 64'(out_valid64), 64'd0);
    check("async_rst_cnt", 64'(cnt32), 64'd0);
    q.delete();
    mcnt32 = '0;
    mcnt64 = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rdy_after_rst2", 64'(in_ready32), 64'd1);

    // Randomised traffic
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 39) == 0);

    for (int i = 0; i < 40 && q.size() != 0; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("final_drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
